// File: rtl/uart_word_tx.sv
// uart_word_tx: sends one 32-bit word as four 8N1 UART bytes, LSB byte first.
// Define UART_WORD_TX_PARITY_EN to add an even-parity bit after each byte.
module uart_word_tx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        send,
  input  logic [31:0] data,
  output logic        busy,
  output logic        done,
  output logic        tx
);

  localparam logic [15:0] BAUD_MAX = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3
`ifdef UART_WORD_TX_PARITY_EN
    , PARITY = 3'd4
`endif
  } state_t;

  state_t      state, state_d;
  logic [15:0] baud_cnt, baud_d;
  logic [2:0]  bit_cnt, bit_d;
  logic [1:0]  byte_cnt, byte_d;
  logic [31:0] shreg, shreg_d;
  logic        tx_d, busy_d, done_d;
  logic        tick;
`ifdef UART_WORD_TX_PARITY_EN
  logic        par, par_d;
`endif

  assign tick = (baud_cnt == BAUD_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef UART_WORD_TX_PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      state    <= state_d;
      baud_cnt <= baud_d;
      bit_cnt  <= bit_d;
      byte_cnt <= byte_d;
      shreg    <= shreg_d;
      tx       <= tx_d;
      busy     <= busy_d;
      done     <= done_d;
`ifdef UART_WORD_TX_PARITY_EN
      par      <= par_d;
`endif
    end
  end

  // Data bits are shifted out of shreg[0]; after eight shifts the next byte
  // already sits in shreg[7:0], so no byte mux is needed.
  always_comb begin
    state_d = state;
    baud_d  = baud_cnt;
    bit_d   = bit_cnt;
    byte_d  = byte_cnt;
    shreg_d = shreg;
`ifdef UART_WORD_TX_PARITY_EN
    par_d   = par;
`endif
    if (state != IDLE) baud_d = tick ? 16'd0 : baud_cnt + 16'd1;
    case (state)
      IDLE: if (send) begin
        state_d = START;
        shreg_d = data;
        baud_d  = '0;
        bit_d   = '0;
        byte_d  = '0;
`ifdef UART_WORD_TX_PARITY_EN
        par_d   = 1'b0;
`endif
      end
      START: if (tick) state_d = DATA;
      DATA: if (tick) begin
        shreg_d = {1'b0, shreg[31:1]};
        bit_d   = bit_cnt + 3'd1;
`ifdef UART_WORD_TX_PARITY_EN
        par_d   = par ^ shreg[0];
        if (bit_cnt == 3'd7) state_d = PARITY;
`else
        if (bit_cnt == 3'd7) state_d = STOP;
`endif
      end
`ifdef UART_WORD_TX_PARITY_EN
      PARITY: if (tick) state_d = STOP;
`endif
      STOP: if (tick) begin
        if (byte_cnt == 2'd3) begin
          state_d = IDLE;
        end else begin
          byte_d  = byte_cnt + 2'd1;
          state_d = START;
`ifdef UART_WORD_TX_PARITY_EN
          par_d   = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // tx is registered, so it is derived from the next state to stay aligned.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_d != IDLE);
    done_d = (state == STOP) && tick && (byte_cnt == 2'd3);
    case (state_d)
      START:  tx_d = 1'b0;
      DATA:   tx_d = shreg_d[0];
`ifdef UART_WORD_TX_PARITY_EN
      PARITY: tx_d = par_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

endmodule
